// File: rtl/axi4_lite_wr_fifo_sequencer_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_wr_fifo_sequencer_if
//
// Bundles the signals between the write sequencer and its surroundings:
// the AW and W FIFO read ports, the B FIFO write port and the simple
// register-bus write port.
//
// Handshake semantics:
//   - AW/W FIFOs are first-word-fall-through. The head (_awaddr, _wdata,
//     _wstrb) is valid while *_rd_empty is low. Asserting *_rd_en for one
//     cycle while not empty consumes the head at the next clock edge.
//   - B FIFO: b_wr_en pushes bresp at the clock edge. It is only asserted
//     while b_wr_full is low.
//   - Register bus: reg_wr_en is held with reg_addr/reg_wdata/reg_wstrb
//     stable until the backend returns a single-cycle reg_wr_ack.
//     reg_wr_err is only meaningful in a cycle where reg_wr_ack is high.
//
// Modports:
//   master : the sequencer side (pops AW/W, pushes B, drives the backend)
//   slave  : the environment side (FIFOs and backend)
// ----------------------------------------------------------------------------
interface axi4_lite_wr_fifo_sequencer_if #(
   parameter int A = 32,
   parameter int N = 4
);
   logic             aw_rd_empty;
   logic [A-1:0]     _awaddr;
   logic             aw_rd_en;
   logic             w_rd_empty;
   logic [8*N-1:0]   _wdata;
   logic [N-1:0]     _wstrb;
   logic             w_rd_en;
   logic             b_wr_full;
   logic             b_wr_en;
   logic [1:0]       bresp;
   logic             reg_wr_en;
   logic [A-1:0]     reg_addr;
   logic [8*N-1:0]   reg_wdata;
   logic [N-1:0]     reg_wstrb;
   logic             reg_wr_ack;
   logic             reg_wr_err;

   modport master (
      input  aw_rd_empty, _awaddr, w_rd_empty, _wdata, _wstrb,
      input  b_wr_full, reg_wr_ack, reg_wr_err,
      output aw_rd_en, w_rd_en, b_wr_en, bresp,
      output reg_wr_en, reg_addr, reg_wdata, reg_wstrb
   );

   modport slave (
      output aw_rd_empty, _awaddr, w_rd_empty, _wdata, _wstrb,
      output b_wr_full, reg_wr_ack, reg_wr_err,
      input  aw_rd_en, w_rd_en, b_wr_en, bresp,
      input  reg_wr_en, reg_addr, reg_wdata, reg_wstrb
   );
endinterface

// File: rtl/axi4_lite_wr_fifo_sequencer.sv
// ----------------------------------------------------------------------------
// axi4_lite_wr_fifo_sequencer
//
// Pops one AW entry and one W entry together, issues a single write on the
// register bus, waits for its completion (or a timeout) and pushes the
// resulting BRESP into the B FIFO. Exactly one write is in flight at a time.
//
// Ports:
//   aclk          clock
//   areset        synchronous active-high reset
//   bus           FIFO + register-bus signals (master modport)
//   busy          high whenever the FSM is not in IDLE
//   timeout_count saturating count of writes completed by timeout (DECERR)
// ----------------------------------------------------------------------------
module axi4_lite_wr_fifo_sequencer #(
   parameter int A        = 32,
   parameter int N        = 4,
   parameter bit USE_STRB = 1'b1,
   parameter int TIMEOUT  = 256
) (
   input  logic                                aclk,
   input  logic                                areset,
   axi4_lite_wr_fifo_sequencer_if.master       bus,
   output logic                                busy,
   output logic [15:0]                         timeout_count
);

   localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int            TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [A-1:0]    addr_q;
   logic [8*N-1:0]  data_q;
   logic [N-1:0]    strb_q;
   logic [1:0]      resp_q, resp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     tc_q, tc_d;
   logic            pop;
   logic            b_push;
   logic [N-1:0]    eff_strb;

   assign eff_strb = USE_STRB ? bus._wstrb : {N{1'b1}};

   always_comb begin
      state_d = state;
      resp_d  = resp_q;
      cnt_d   = cnt_q;
      tc_d    = tc_q;
      pop     = 1'b0;
      b_push  = 1'b0;
      case (state)
         IDLE: begin
            // Both heads must be present in the same cycle; the pair is
            // always consumed together. Gated by reset so nothing is popped
            // in a cycle that is about to be discarded.
            if (!areset && !bus.aw_rd_empty && !bus.w_rd_empty) begin
               pop = 1'b1;
               if (eff_strb == '0) begin
                  // Nothing to write: complete without touching the backend.
                  state_d = RESP;
                  resp_d  = RESP_OKAY;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
               end
            end
         end
         REQ: begin
            // An ack in the timeout cycle takes priority over the timeout.
            if (bus.reg_wr_ack) begin
               resp_d  = bus.reg_wr_err ? RESP_SLVERR : RESP_OKAY;
               state_d = RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == TLIM_C)) begin
               resp_d  = RESP_DECERR;
               tc_d    = (tc_q == 16'hFFFF) ? tc_q : tc_q + 16'd1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (!areset && !bus.b_wr_full) begin
               b_push  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state  <= IDLE;
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
         resp_q <= '0;
         cnt_q  <= '0;
         tc_q   <= '0;
      end else begin
         state  <= state_d;
         resp_q <= resp_d;
         cnt_q  <= cnt_d;
         tc_q   <= tc_d;
         if (pop) begin
            addr_q <= bus._awaddr;
            data_q <= bus._wdata;
            strb_q <= eff_strb;
         end
      end
   end

   assign bus.aw_rd_en   = pop;
   assign bus.w_rd_en    = pop;
   assign bus.reg_wr_en  = (state == REQ);
   assign bus.reg_addr   = addr_q;
   assign bus.reg_wdata  = data_q;
   assign bus.reg_wstrb  = strb_q;
   assign bus.b_wr_en    = b_push;
   assign bus.bresp      = resp_q;
   assign busy           = (state != IDLE);
   assign timeout_count  = tc_q;

endmodule
